frame_buffer_dbl: RTL and testbench
===================================

# frame_buffer_dbl

Parametrised, double-buffered pixel frame buffer with a hardware page-clear engine, on one clock. The processor side (port A) reads and writes the back page. The VGA side (port B) reads the front page. The two pages swap only at a frame boundary, which gives tear-free updates. It sits between the microprocessor bus and the VGA signal generator, which is clocked from the same clock with its own pixel enable.

## Interface
Parameters:
- X_BITS, 8, column address width (LSBs of address)
- Y_BITS, 7, row address width (MSBs of address)
- PIX_W, 1, bits per pixel (colour depth)
- Derived: AW = X_BITS+Y_BITS, N = 2**AW pixels per page; storage is 2 pages × N × PIX_W

Ports:
- CLK  in  1  single clock for both ports and control
- RESET  in  1  synchronous, active-high reset
- A_ADDR  in  AW  back-page pixel address {Y,X}
- A_DATA_IN  in  PIX_W  write data
- A_WE  in  1  write enable (back page)
- A_DATA_OUT  out  PIX_W  registered back-page read data
- B_ADDR  in  AW  front-page pixel address from VGA generator
- B_DATA  out  PIX_W  registered front-page read data
- FRAME_START  in  1  one-cycle pulse from VGA generator at start of vertical blanking
- SWAP_REQ  in  1  one-cycle pulse requesting page swap
- SWAP_PENDING  out  1  swap requested, not yet performed
- FRONT_SEL  out  1  index of page currently displayed
- CLEAR_REQ  in  1  one-cycle pulse: fill back page with CLEAR_VALUE
- CLEAR_VALUE  in  PIX_W  fill value, sampled when CLEAR_REQ is accepted
- BUSY  out  1  clear engine active

## Operation
- Back page = ~FRONT_SEL. All port-A accesses and all clears target the back page. Port B always reads page FRONT_SEL.
- Memory contents are not reset. Reset values: FRONT_SEL=0, SWAP_PENDING=0, BUSY=0, A_DATA_OUT=0, B_DATA=0, clear counter=0, state IDLE.
- Port A:
  - Write-first. When a write is accepted, A_DATA_OUT shows the new data on the next cycle.
  - Otherwise A_DATA_OUT shows old contents.
- Clear FSM, two states:
  - IDLE: CLEAR_REQ=1 → latch CLEAR_VALUE, counter←0, go to CLEAR.
  - CLEAR: write latched value to back[counter] each cycle. Counter increments. At counter=N-1, the write is done and the FSM returns to IDLE. No wrap-around beyond N-1.
  - BUSY=1 exactly while in CLEAR.
- While BUSY, or in the cycle CLEAR_REQ is accepted:
  - A_WE is ignored and the write is dropped.
  - Port-A reads still complete.
  - CLEAR_REQ while BUSY is ignored.
- Swap logic:
  - SWAP_REQ sets SWAP_PENDING. A repeated SWAP_REQ while pending has no extra effect.
  - A swap occurs in a cycle where FRAME_START=1, (SWAP_PENDING=1 or SWAP_REQ=1), and state is IDLE with no CLEAR_REQ that cycle. In that cycle: FRONT_SEL toggles and SWAP_PENDING clears, both visible next cycle.
  - FRAME_START while BUSY: no swap; the request stays pending until the next qualifying FRAME_START.
  - FRAME_START with nothing pending: no effect.
- A port-A access in the swap cycle uses the pre-swap back page.
- A port-B read in the swap cycle uses the pre-swap front page.

## Timing
- Port A read latency 1 cycle. Port B read latency 1 cycle.
- The two ports are independent and may access the same page address in the same cycle.
- Clear: CLEAR_REQ accepted at cycle t → BUSY=1 cycles t+1..t+N, writing address k at cycle t+1+k. BUSY=0 at t+N+1, when port-A writes are accepted again.
- Swap: qualifying FRAME_START at cycle t → FRONT_SEL flipped and SWAP_PENDING=0 at t+1. B_DATA reflects the new page for addresses presented at t+1 onward, visible at t+2.
- RESET mid-clear: FSM returns to IDLE, BUSY=0 next cycle. The back page is left partially cleared. Pending swap is discarded.
- RESET has priority over all other inputs in the same cycle.

## Test plan
Bench configuration: X_BITS=3, Y_BITS=2, PIX_W=4 (N=32).
- Reset, then write 0xA to A_ADDR=5 and read back → A_DATA_OUT=0xA one cycle after the read; B_ADDR=5 returns prior front data, not 0xA; FRONT_SEL=0.
- SWAP_REQ at cycle 10, FRAME_START at cycle 20 → SWAP_PENDING=1 on cycles 11..20 and 0 at 21; FRONT_SEL=1 at 21; B_ADDR=5 presented at 21 gives B_DATA=0xA at 22.
- CLEAR_REQ with CLEAR_VALUE=0x3 at cycle t → BUSY high for exactly 32 cycles; A_WE of 0xF to address 7 during BUSY is dropped; all 32 back-page addresses then read 0x3; front page unchanged.
- SWAP_REQ at clear start, FRAME_START mid-clear and again after BUSY falls → no swap mid-clear; FRONT_SEL toggles only after the second FRAME_START.
- SWAP_REQ and FRAME_START in the same cycle while IDLE → FRONT_SEL toggles next cycle; SWAP_PENDING never observed high.
- RESET asserted at clear cycle 10 → BUSY=0 and FRONT_SEL=0 next cycle; addresses 0..8 read CLEAR_VALUE, addresses ≥10 keep old data; a new CLEAR_REQ afterwards completes in 32 cycles.

Source files
------------

// File: rtl/frame_buffer_dbl_if.sv
// Bus bundle between the processor / VGA generator (master) and the double-buffered frame store (slave).
interface frame_buffer_dbl_if #(
    parameter int unsigned X_BITS = 8,
    parameter int unsigned Y_BITS = 7,
    parameter int unsigned PIX_W  = 1
);
    localparam int unsigned AW = X_BITS + Y_BITS;

    logic [AW-1:0]    A_ADDR;
    logic [PIX_W-1:0] A_DATA_IN;
    logic             A_WE;
    logic [PIX_W-1:0] A_DATA_OUT;
    logic [AW-1:0]    B_ADDR;
    logic [PIX_W-1:0] B_DATA;
    logic             FRAME_START;
    logic             SWAP_REQ;
    logic             SWAP_PENDING;
    logic             FRONT_SEL;
    logic             CLEAR_REQ;
    logic [PIX_W-1:0] CLEAR_VALUE;
    logic             BUSY;

    modport master (
        output A_ADDR, A_DATA_IN, A_WE, B_ADDR, FRAME_START, SWAP_REQ, CLEAR_REQ, CLEAR_VALUE,
        input  A_DATA_OUT, B_DATA, SWAP_PENDING, FRONT_SEL, BUSY
    );

    modport slave (
        input  A_ADDR, A_DATA_IN, A_WE, B_ADDR, FRAME_START, SWAP_REQ, CLEAR_REQ, CLEAR_VALUE,
        output A_DATA_OUT, B_DATA, SWAP_PENDING, FRONT_SEL, BUSY
    );
endinterface

// File: rtl/frame_buffer_dbl.sv
// Double-buffered pixel frame store: port A owns the back page, port B displays the front page,
// pages swap only on a frame boundary, and a clear engine fills the back page one pixel per cycle.
module frame_buffer_dbl #(
    parameter int unsigned X_BITS = 8,
    parameter int unsigned Y_BITS = 7,
    parameter int unsigned PIX_W  = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    frame_buffer_dbl_if.slave bus
);
    localparam int unsigned AW = X_BITS + Y_BITS;
    localparam int unsigned N  = 2 ** AW;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [PIX_W-1:0] clr_val_q, clr_val_d;
    logic             front_q, front_d;
    logic             pend_q, pend_d;
    logic             busy_q;
    logic [PIX_W-1:0] a_data_q;
    logic [PIX_W-1:0] b_data_q;

    logic [PIX_W-1:0] mem [2*N];

    logic             a_wr_c;
    logic             swap_c;
    logic             mem_we_c;
    logic [AW:0]      mem_waddr_c;
    logic [PIX_W-1:0] mem_wdata_c;

    // Clear FSM, port-A write arbitration and swap decision.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clr_val_d   = clr_val_q;
        front_d     = front_q;
        pend_d      = pend_q;
        a_wr_c      = 1'b0;
        swap_c      = 1'b0;
        mem_we_c    = 1'b0;
        mem_waddr_c = {~front_q, bus.A_ADDR};
        mem_wdata_c = bus.A_DATA_IN;

        case (state_q)
            IDLE: begin
                if (bus.CLEAR_REQ) begin
                    state_d   = CLEAR;
                    cnt_d     = '0;
                    clr_val_d = bus.CLEAR_VALUE;
                end else if (bus.A_WE) begin
                    a_wr_c   = 1'b1;
                    mem_we_c = 1'b1;
                end
            end
            CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = {~front_q, cnt_q};
                mem_wdata_c = clr_val_q;
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
        endcase

        // Swap only when idle, not starting a clear, and a request is present or arriving.
        swap_c = bus.FRAME_START && (pend_q || bus.SWAP_REQ) &&
                 (state_q == IDLE) && !bus.CLEAR_REQ;
        if (swap_c) begin
            front_d = ~front_q;
            pend_d  = 1'b0;
        end else if (bus.SWAP_REQ) begin
            pend_d = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            clr_val_q <= '0;
            front_q   <= 1'b0;
            pend_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_val_q <= clr_val_d;
            front_q   <= front_d;
            pend_q    <= pend_d;
            busy_q    <= (state_d == CLEAR);
        end
    end

    // Pixel storage write port; contents are never reset and reset blocks writes.
    always_ff @(posedge CLK) begin
        if (mem_we_c && !RESET) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Registered read ports; port A is write-first for accepted writes, uses pre-swap pages.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            a_data_q <= a_wr_c ? bus.A_DATA_IN : mem[{~front_q, bus.A_ADDR}];
            b_data_q <= mem[{front_q, bus.B_ADDR}];
        end
    end

    assign bus.A_DATA_OUT   = a_data_q;
    assign bus.B_DATA       = b_data_q;
    assign bus.SWAP_PENDING = pend_q;
    assign bus.FRONT_SEL    = front_q;
    assign bus.BUSY         = busy_q;
endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Scoreboard bench for frame_buffer_dbl: reads push expected pixels, a monitor pops and compares.
module tb_frame_buffer_dbl;
    localparam int unsigned XB = 3;
    localparam int unsigned YB = 2;
    localparam int unsigned PW = 4;
    localparam int unsigned N  = 32;

    typedef struct packed {
        logic [4:0] addr;
        logic [3:0] val;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    frame_buffer_dbl_if #(.X_BITS(XB), .Y_BITS(YB), .PIX_W(PW)) bus ();

    frame_buffer_dbl #(.X_BITS(XB), .Y_BITS(YB), .PIX_W(PW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   vectors     = 0;
    int   miscompares = 0;
    logic a_iss = 1'b0;
    logic b_iss = 1'b0;
    logic a_chk = 1'b0;
    logic b_chk = 1'b0;

    // Read data is due one cycle after the read is issued.
    always @(posedge CLK) begin
        a_chk <= a_iss;
        b_chk <= b_iss;
    end

    // Monitor: compare registered read data against the scoreboard on the falling edge.
    always @(negedge CLK) begin
        if (a_chk) begin
            vectors++;
            if (qa.size() == 0) begin
                miscompares++;
                $display("FAIL a_read: unexpected data %h, scoreboard empty", bus.A_DATA_OUT);
            end else begin
                ea = qa.pop_front();
                if (bus.A_DATA_OUT !== ea.val) begin
                    miscompares++;
                    $display("FAIL a_read[%0d]: got %h expected %h", ea.addr, bus.A_DATA_OUT, ea.val);
                end
            end
        end
        if (b_chk) begin
            vectors++;
            if (qb.size() == 0) begin
                miscompares++;
                $display("FAIL b_read: unexpected data %h, scoreboard empty", bus.B_DATA);
            end else begin
                eb = qb.pop_front();
                if (bus.B_DATA !== eb.val) begin
                    miscompares++;
                    $display("FAIL b_read[%0d]: got %h expected %h", eb.addr, bus.B_DATA, eb.val);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
        bus.A_WE        = 1'b0;
        bus.SWAP_REQ    = 1'b0;
        bus.FRAME_START = 1'b0;
        bus.CLEAR_REQ   = 1'b0;
        a_iss           = 1'b0;
        b_iss           = 1'b0;
    endtask

    task automatic rd_a(input logic [4:0] addr, input logic [3:0] v);
        bus.A_ADDR = addr;
        a_iss      = 1'b1;
        qa.push_back({addr, v});
    endtask

    task automatic rd_b(input logic [4:0] addr, input logic [3:0] v);
        bus.B_ADDR = addr;
        b_iss      = 1'b1;
        qb.push_back({addr, v});
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_clear(input logic [3:0] v);
        bus.CLEAR_VALUE = v;
        bus.CLEAR_REQ   = 1'b1;
        cyc();
        repeat (N) cyc();
    endtask

    task automatic swap_now(input logic exp_front);
        bus.SWAP_REQ    = 1'b1;
        bus.FRAME_START = 1'b1;
        cyc();
        chk("same_cycle_swap_front", 4'(bus.FRONT_SEL), 4'(exp_front));
        chk("same_cycle_swap_pend", 4'(bus.SWAP_PENDING), 4'h0);
    endtask

    // Bound the run in case the design stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET           = 1'b1;
        bus.A_ADDR      = '0;
        bus.A_DATA_IN   = '0;
        bus.A_WE        = 1'b0;
        bus.B_ADDR      = '0;
        bus.FRAME_START = 1'b0;
        bus.SWAP_REQ    = 1'b0;
        bus.CLEAR_REQ   = 1'b0;
        bus.CLEAR_VALUE = '0;
        repeat (2) cyc();
        chk("rst_front", 4'(bus.FRONT_SEL), 4'h0);
        chk("rst_busy", 4'(bus.BUSY), 4'h0);
        chk("rst_pend", 4'(bus.SWAP_PENDING), 4'h0);
        chk("rst_a_data", bus.A_DATA_OUT, 4'h0);
        chk("rst_b_data", bus.B_DATA, 4'h0);
        RESET = 1'b0;

        // Known contents: page0 = 2 (front), page1 = 1 (back).
        do_clear(4'h1);
        swap_now(1'b1);
        do_clear(4'h2);
        swap_now(1'b0);

        // Write-first on port A; port B still sees front data.
        bus.A_DATA_IN = 4'hA;
        bus.A_WE      = 1'b1;
        rd_a(5'd5, 4'hA);
        rd_b(5'd5, 4'h2);
        cyc();
        rd_a(5'd5, 4'hA);
        cyc();
        rd_a(5'd6, 4'h1);
        cyc();
        chk("t1_front", 4'(bus.FRONT_SEL), 4'h0);

        // Pending swap held across idle cycles, taken on FRAME_START.
        bus.SWAP_REQ = 1'b1;
        cyc();
        for (int i = 0; i < 9; i++) begin
            chk("t2_pend_hold", 4'(bus.SWAP_PENDING), 4'h1);
            if (i == 4) bus.SWAP_REQ = 1'b1;
            cyc();
        end
        chk("t2_pend_before", 4'(bus.SWAP_PENDING), 4'h1);
        bus.FRAME_START = 1'b1;
        rd_b(5'd5, 4'h2);
        rd_a(5'd6, 4'h1);
        cyc();
        chk("t2_pend_after", 4'(bus.SWAP_PENDING), 4'h0);
        chk("t2_front_after", 4'(bus.FRONT_SEL), 4'h1);
        rd_b(5'd5, 4'hA);
        rd_a(5'd5, 4'h2);
        cyc();

        // Clear back page (page0) to 3 with a swap request and mid-clear FRAME_START.
        bus.CLEAR_VALUE = 4'h3;
        bus.CLEAR_REQ   = 1'b1;
        bus.SWAP_REQ    = 1'b1;
        bus.A_WE        = 1'b1;
        bus.A_ADDR      = 5'd9;
        bus.A_DATA_IN   = 4'hF;
        cyc();
        for (int k = 0; k < 32; k++) begin
            chk("t3_busy_high", 4'(bus.BUSY), 4'h1);
            if (k == 15) bus.FRAME_START = 1'b1;
            if (k == 16) begin
                chk("t4_front_mid", 4'(bus.FRONT_SEL), 4'h1);
                chk("t4_pend_mid", 4'(bus.SWAP_PENDING), 4'h1);
            end
            if (k == 20) begin
                bus.A_WE      = 1'b1;
                bus.A_ADDR    = 5'd7;
                bus.A_DATA_IN = 4'hF;
            end
            cyc();
        end
        chk("t3_busy_low", 4'(bus.BUSY), 4'h0);
        chk("t4_front_post", 4'(bus.FRONT_SEL), 4'h1);
        chk("t4_pend_post", 4'(bus.SWAP_PENDING), 4'h1);
        for (int i = 0; i < 32; i++) begin
            rd_a(5'(i), 4'h3);
            rd_b(5'(i), (i == 5) ? 4'hA : 4'h1);
            cyc();
        end
        bus.FRAME_START = 1'b1;
        cyc();
        chk("t4_front_swap", 4'(bus.FRONT_SEL), 4'h0);
        chk("t4_pend_clear", 4'(bus.SWAP_PENDING), 4'h0);

        // FRAME_START with nothing pending does nothing.
        bus.FRAME_START = 1'b1;
        cyc();
        chk("t5_idle_frame", 4'(bus.FRONT_SEL), 4'h0);

        // Reset in the middle of clearing page1 to C.
        bus.CLEAR_VALUE = 4'hC;
        bus.CLEAR_REQ   = 1'b1;
        bus.SWAP_REQ    = 1'b1;
        cyc();
        for (int k = 0; k < 9; k++) cyc();
        chk("t6_pend_set", 4'(bus.SWAP_PENDING), 4'h1);
        chk("t6_busy_set", 4'(bus.BUSY), 4'h1);
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        chk("t6_busy_rst", 4'(bus.BUSY), 4'h0);
        chk("t6_front_rst", 4'(bus.FRONT_SEL), 4'h0);
        chk("t6_pend_rst", 4'(bus.SWAP_PENDING), 4'h0);
        chk("t6_a_data_rst", bus.A_DATA_OUT, 4'h0);
        for (int i = 0; i < 32; i++) begin
            if (i != 9) begin
                rd_a(5'(i), (i < 9) ? 4'hC : 4'h1);
                rd_b(5'(i), 4'h3);
                cyc();
            end
        end
        bus.FRAME_START = 1'b1;
        cyc();
        chk("t6_no_swap", 4'(bus.FRONT_SEL), 4'h0);

        // A fresh clear completes in exactly 32 busy cycles.
        bus.CLEAR_VALUE = 4'h6;
        bus.CLEAR_REQ   = 1'b1;
        cyc();
        for (int k = 0; k < 32; k++) begin
            chk("t6_busy2_high", 4'(bus.BUSY), 4'h1);
            cyc();
        end
        chk("t6_busy2_low", 4'(bus.BUSY), 4'h0);
        for (int i = 0; i < 32; i++) begin
            rd_a(5'(i), 4'h6);
            cyc();
        end
        cyc();
        cyc();

        vectors++;
        if (qa.size() != 0 || qb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d reads never returned, expected 0", qa.size(), qb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
